// File: rtl/decode_issue_stage.sv
// Purpose: RISC-V decode/issue stage; decodes DE, reads operands, tracks in-flight rd in a scoreboard.
// Latency: one cycle from DE acceptance to a registered EXE bundle.
// Backpressure: bundle holds while exe_v && !exe_ready; de_ready drops on hazard, full output or flush.
// Ports: DE side (de_v/de_npc/de_ir/de_ready), register-file read (rs*_addr/rs*_data),
//        write-back (wb_v/wb_kill/wb_rd/wb_data), EXE side (flush/exe_ready/exe_*).
// Option: define DECODE_FWD_EN to forward wb_data into the source operands in the write-back cycle.
module decode_issue_stage #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            de_v,
  input  logic [XLEN-1:0] de_npc,
  input  logic [31:0]     de_ir,
  output logic            de_ready,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            wb_v,
  input  logic            wb_kill,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  input  logic            exe_ready,
  output logic            exe_v,
  output logic            exe_illegal,
  output logic [31:0]     exe_ir,
  output logic [XLEN-1:0] exe_npc,
  output logic [XLEN-1:0] exe_alu1,
  output logic [XLEN-1:0] exe_alu2,
  output logic [XLEN-1:0] exe_target,
  output logic [XLEN-1:0] exe_mem_addr
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_R32    = 7'b0111011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic [6:0] opcode;
  logic [4:0] rd;
  assign opcode   = de_ir[6:0];
  assign rd       = de_ir[11:7];
  assign rs1_addr = de_ir[19:15];
  assign rs2_addr = de_ir[24:20];

  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  assign imm_i = XLEN'($signed(de_ir[31:20]));
  assign imm_s = XLEN'($signed({de_ir[31:25], de_ir[11:7]}));
  assign imm_b = XLEN'($signed({de_ir[31], de_ir[7], de_ir[30:25], de_ir[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({de_ir[31:12], 12'h000}));
  assign imm_j = XLEN'($signed({de_ir[31], de_ir[19:12], de_ir[20], de_ir[30:21], 1'b0}));

  logic is_load, is_store, is_r, is_imm, is_br, is_lui, is_auipc, is_jal, is_jalr;
  assign is_load  = (opcode == OP_LOAD);
  assign is_store = (opcode == OP_STORE);
  assign is_r     = (opcode == OP_R)   || ((XLEN == 64) && (opcode == OP_R32));
  assign is_imm   = (opcode == OP_IMM) || ((XLEN == 64) && (opcode == OP_IMM32));
  assign is_br    = (opcode == OP_BRANCH);
  assign is_lui   = (opcode == OP_LUI);
  assign is_auipc = (opcode == OP_AUIPC);
  assign is_jal   = (opcode == OP_JAL);
  assign is_jalr  = (opcode == OP_JALR);

  logic legal, use_rs1, use_rs2, wr_rd;
  assign legal   = is_load | is_store | is_r | is_imm | is_br | is_lui | is_auipc | is_jal | is_jalr;
  assign use_rs1 = legal && !(is_lui || is_auipc || is_jal);
  assign use_rs2 = is_store | is_r | is_br;
  assign wr_rd   = legal && !(is_store || is_br) && (rd != 5'd0);

  // A retiring (not killed) result matching a checked source bypasses the scoreboard this cycle.
  logic fwd1, fwd2;
`ifdef DECODE_FWD_EN
  assign fwd1 = wb_v && !wb_kill && (wb_rd == rs1_addr) && (rs1_addr != 5'd0);
  assign fwd2 = wb_v && !wb_kill && (wb_rd == rs2_addr) && (rs2_addr != 5'd0);
`else
  assign fwd1 = 1'b0;
  assign fwd2 = 1'b0;
  logic unused_wb_kill;
  assign unused_wb_kill = wb_kill;
`endif

  logic [XLEN-1:0] src1, src2;
  assign src1 = fwd1 ? wb_data : rs1_data;
  assign src2 = fwd2 ? wb_data : rs2_data;

  logic [31:0] pending, pending_nxt;
  logic        stall, issue;
  assign stall = (use_rs1 && pending[rs1_addr] && !fwd1)
              || (use_rs2 && pending[rs2_addr] && !fwd2)
              || (wr_rd && pending[rd]);
  assign de_ready = !flush && !stall && (!exe_v || exe_ready);
  assign issue    = de_v && de_ready;

  // Set after clear so an issue targeting the retiring register stays pending.
  always_comb begin
    pending_nxt = pending;
    if (wb_v) pending_nxt[wb_rd] = 1'b0;
    if (issue && wr_rd) pending_nxt[rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  logic [XLEN-1:0] alu1, alu2, target, mem_addr, jalr_sum;
  assign jalr_sum = src1 + imm_i;

  always_comb begin
    alu1     = '0;
    alu2     = '0;
    target   = '0;
    mem_addr = '0;
    if (is_load) begin
      alu1 = src1; alu2 = imm_i; mem_addr = src1 + imm_i;
    end else if (is_store) begin
      alu1 = src1; alu2 = src2; mem_addr = src1 + imm_s;
    end else if (is_r) begin
      alu1 = src1; alu2 = src2;
    end else if (is_imm) begin
      alu1 = src1; alu2 = imm_i;
    end else if (is_br) begin
      alu1 = src1; alu2 = src2; target = de_npc + imm_b;
    end else if (is_lui) begin
      alu1 = imm_u;
    end else if (is_auipc) begin
      alu1 = imm_u; alu2 = de_npc;
    end else if (is_jal) begin
      alu1 = de_npc; alu2 = imm_j; target = de_npc + imm_j;
    end else if (is_jalr) begin
      alu1 = de_npc; target = {jalr_sum[XLEN-1:1], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending      <= '0;
      exe_v        <= 1'b0;
      exe_illegal  <= 1'b0;
      exe_ir       <= '0;
      exe_npc      <= '0;
      exe_alu1     <= '0;
      exe_alu2     <= '0;
      exe_target   <= '0;
      exe_mem_addr <= '0;
    end else begin
      pending <= pending_nxt;
      if (flush) begin
        exe_v       <= 1'b0;
        exe_illegal <= 1'b0;
      end else if (issue) begin
        exe_v        <= 1'b1;
        exe_illegal  <= !legal;
        exe_ir       <= de_ir;
        exe_npc      <= de_npc;
        exe_alu1     <= alu1;
        exe_alu2     <= alu2;
        exe_target   <= target;
        exe_mem_addr <= mem_addr;
      end else if (exe_ready) begin
        exe_v <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_decode_issue_stage.sv
module tb_decode_issue_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        de_v;
  logic [63:0] de_npc;
  logic [31:0] de_ir;
  logic        de_ready;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [63:0] rs1_data, rs2_data;
  logic        wb_v, wb_kill;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        flush, exe_ready;
  logic        exe_v, exe_illegal;
  logic [31:0] exe_ir;
  logic [63:0] exe_npc, exe_alu1, exe_alu2, exe_target, exe_mem_addr;

  logic [63:0] regs [32];
  assign rs1_data = regs[rs1_addr];
  assign rs2_data = regs[rs2_addr];

  always #5 clk = ~clk;

  decode_issue_stage #(.XLEN(64)) dut (
    .clk(clk), .rst_n(rst_n), .de_v(de_v), .de_npc(de_npc), .de_ir(de_ir),
    .de_ready(de_ready), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .wb_v(wb_v), .wb_kill(wb_kill),
    .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush), .exe_ready(exe_ready),
    .exe_v(exe_v), .exe_illegal(exe_illegal), .exe_ir(exe_ir), .exe_npc(exe_npc),
    .exe_alu1(exe_alu1), .exe_alu2(exe_alu2), .exe_target(exe_target),
    .exe_mem_addr(exe_mem_addr)
  );

  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else pass_cnt++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, 3'b000, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
    return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rd, op};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction
  function automatic logic [31:0] enc_r(input logic [4:0] rs2, input logic [4:0] rs1, input logic [4:0] rd);
    return {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  typedef struct {
    logic [31:0] ir;
    logic [63:0] npc;
    logic [63:0] v1;
    logic [63:0] v2;
    logic        use2;
    logic [63:0] a1;
    logic [63:0] a2;
    logic [63:0] tgt;
    logic [63:0] mem;
    logic        ill;
    logic [4:0]  rd;
  } vec_t;

  localparam int NVEC = 12;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  vec_t vecs [NVEC];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [4:0] r1, r2;

    //         ir                                        npc       v1                     v2      u2  a1                     a2        tgt      mem       ill rd
    vecs[0]  = '{enc_i(12'd8, 5'd2, 5'd5, 7'b0000011),    64'h0,    64'h1000,              64'h0,  0, 64'h1000,              64'h8,    64'h0,   64'h1008, 0, 5'd5};
    vecs[1]  = '{enc_s(12'hFFC, 5'd7, 5'd8),              64'h0,    64'h2000,              64'hAB, 1, 64'h2000,              64'hAB,   64'h0,   64'h1FFC, 0, 5'd0};
    vecs[2]  = '{enc_r(5'd1, 5'd5, 5'd6),                 64'h0,    64'h3,                 64'h4,  1, 64'h3,                 64'h4,    64'h0,   64'h0,    0, 5'd6};
    vecs[3]  = '{enc_i(12'hFFF, 5'd10, 5'd9, 7'b0010011), 64'h0,    64'h5,                 64'h0,  0, 64'h5,                 ONES,     64'h0,   64'h0,    0, 5'd9};
    vecs[4]  = '{enc_b(13'h1FF8, 5'd12, 5'd11),           64'h200,  64'h1,                 64'h2,  1, 64'h1,                 64'h2,    64'h1F8, 64'h0,    0, 5'd0};
    vecs[5]  = '{enc_u(20'h80000, 5'd13, 7'b0110111),     64'h0,    64'h0,                 64'h0,  0, 64'hFFFF_FFFF_8000_0000, 64'h0,  64'h0,   64'h0,    0, 5'd13};
    vecs[6]  = '{enc_u(20'h00001, 5'd14, 7'b0010111),     64'h300,  64'h0,                 64'h0,  0, 64'h1000,              64'h300,  64'h0,   64'h0,    0, 5'd14};
    vecs[7]  = '{enc_j(21'h10, 5'd1),                     64'h400,  64'h0,                 64'h0,  0, 64'h400,               64'h10,   64'h410, 64'h0,    0, 5'd1};
    vecs[8]  = '{enc_i(12'd4, 5'd3, 5'd1, 7'b1100111),    64'h100,  64'h2001,              64'h0,  0, 64'h100,               64'h0,    64'h2004, 64'h0,   0, 5'd1};
    vecs[9]  = '{32'h0000_007F,                           64'h0,    64'h0,                 64'h0,  0, 64'h0,                 64'h0,    64'h0,   64'h0,    1, 5'd0};
    vecs[10] = '{enc_i(12'd1, 5'd16, 5'd15, 7'b0011011),  64'h0,    64'h0000_0000_FFFF_FFFF, 64'h0, 0, 64'h0000_0000_FFFF_FFFF, 64'h1, 64'h0,  64'h0,    0, 5'd15};
    vecs[11] = '{enc_i(12'hFFF, 5'd18, 5'd17, 7'b0000011),64'h0,    64'h0,                 64'h0,  0, 64'h0,                 ONES,     64'h0,   ONES,     0, 5'd17};

    for (int i = 0; i < 32; i++) regs[i] = '0;
    rst_n = 1'b0; de_v = 1'b0; de_npc = '0; de_ir = '0; wb_v = 1'b0; wb_kill = 1'b0;
    wb_rd = '0; wb_data = '0; flush = 1'b0; exe_ready = 1'b1;

    // Reset state
    #12;
    chk("rst_exe_v", 64'(exe_v), 64'd0);
    chk("rst_exe_illegal", 64'(exe_illegal), 64'd0);
    chk("rst_exe_alu1", exe_alu1, 64'd0);
    chk("rst_exe_target", exe_target, 64'd0);
    chk("rst_de_ready", 64'(de_ready), 64'd1);
    rst_n = 1'b1;
    tick();

    // Decode table, one instruction at a time, pending cleared by a write-back after each
    for (int i = 0; i < NVEC; i++) begin
      r1 = vecs[i].ir[19:15];
      r2 = vecs[i].ir[24:20];
      if (r1 != 5'd0) regs[r1] = vecs[i].v1;
      if (vecs[i].use2 && r2 != 5'd0) regs[r2] = vecs[i].v2;
      de_ir = vecs[i].ir; de_npc = vecs[i].npc; de_v = 1'b1; exe_ready = 1'b1;
      #1;
      chk($sformatf("v%0d_de_ready", i), 64'(de_ready), 64'd1);
      tick();
      chk($sformatf("v%0d_exe_v", i), 64'(exe_v), 64'd1);
      chk($sformatf("v%0d_illegal", i), 64'(exe_illegal), 64'(vecs[i].ill));
      chk($sformatf("v%0d_alu1", i), exe_alu1, vecs[i].a1);
      chk($sformatf("v%0d_alu2", i), exe_alu2, vecs[i].a2);
      chk($sformatf("v%0d_target", i), exe_target, vecs[i].tgt);
      chk($sformatf("v%0d_mem_addr", i), exe_mem_addr, vecs[i].mem);
      de_v = 1'b0; wb_v = 1'b1; wb_rd = vecs[i].rd;
      tick();
      wb_v = 1'b0;
    end

    // RAW: add x6,x5,x1 behind load x5,8(x2)
    regs[2] = 64'h1000; regs[1] = 64'h4;
    de_ir = enc_i(12'd8, 5'd2, 5'd5, 7'b0000011); de_npc = '0; de_v = 1'b1;
    tick();
    chk("raw_load_mem_addr", exe_mem_addr, 64'h1008);
    de_ir = enc_r(5'd1, 5'd5, 5'd6);
    #1;
    chk("raw_stall_c1", 64'(de_ready), 64'd0);
    tick();
    chk("raw_stall_c2", 64'(de_ready), 64'd0);
    regs[5] = 64'd99; wb_v = 1'b1; wb_kill = 1'b0; wb_rd = 5'd5; wb_data = 64'd7;
    #1;
`ifdef DECODE_FWD_EN
    chk("raw_fwd_ready", 64'(de_ready), 64'd1);
    tick();
    wb_v = 1'b0; de_v = 1'b0; regs[5] = 64'd7;
    chk("raw_fwd_alu1", exe_alu1, 64'd7);
    chk("raw_fwd_alu2", exe_alu2, 64'd4);
`else
    chk("raw_wb_cycle_ready", 64'(de_ready), 64'd0);
    tick();
    wb_v = 1'b0; regs[5] = 64'd7;
    #1;
    chk("raw_after_wb_ready", 64'(de_ready), 64'd1);
    tick();
    de_v = 1'b0;
    chk("raw_alu1", exe_alu1, 64'd7);
    chk("raw_alu2", exe_alu2, 64'd4);
`endif
    wb_v = 1'b1; wb_rd = 5'd6;
    tick();
    wb_v = 1'b0;

    // Backpressure: exe_ready low for 3 cycles
    de_ir = enc_i(12'd1, 5'd0, 5'd20, 7'b0010011); de_v = 1'b1; exe_ready = 1'b0;
    tick();
    de_ir = enc_i(12'd2, 5'd0, 5'd21, 7'b0010011);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("bp%0d_de_ready", c), 64'(de_ready), 64'd0);
      chk($sformatf("bp%0d_exe_v", c), 64'(exe_v), 64'd1);
      chk($sformatf("bp%0d_alu2_hold", c), exe_alu2, 64'd1);
      tick();
    end
    exe_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(de_ready), 64'd1);
    tick();
    de_v = 1'b0;
    chk("bp_next_alu2", exe_alu2, 64'd2);
    chk("bp_next_exe_v", 64'(exe_v), 64'd1);
    wb_v = 1'b1; wb_rd = 5'd20;
    tick();
    wb_rd = 5'd21;
    tick();
    wb_v = 1'b0;

    // JALR x1,4(x3), then flush
    regs[3] = 64'h2001;
    de_ir = enc_i(12'd4, 5'd3, 5'd1, 7'b1100111); de_npc = 64'h100; de_v = 1'b1; exe_ready = 1'b0;
    tick();
    chk("jalr_exe_v", 64'(exe_v), 64'd1);
    chk("jalr_target", exe_target, 64'h2004);
    chk("jalr_alu1", exe_alu1, 64'h100);
    de_ir = enc_r(5'd0, 5'd1, 5'd2); exe_ready = 1'b1;
    #1;
    chk("jalr_pending_x1_stall", 64'(de_ready), 64'd0);
    de_v = 1'b0; exe_ready = 1'b0; flush = 1'b1;
    tick();
    chk("flush_exe_v", 64'(exe_v), 64'd0);
    de_ir = enc_i(12'd5, 5'd0, 5'd22, 7'b0010011); de_v = 1'b1; exe_ready = 1'b1;
    #1;
    chk("flush_blocks_issue", 64'(de_ready), 64'd0);
    tick();
    chk("flush_no_issue", 64'(exe_v), 64'd0);
    flush = 1'b0; de_v = 1'b0; wb_v = 1'b1; wb_rd = 5'd1;
    tick();
    wb_v = 1'b0;

    // Illegal opcode with rd field x5 sets no pending bit; x0 never stalls
    de_ir = 32'h0000_02FF; de_v = 1'b1;
    tick();
    chk("ill_exe_v", 64'(exe_v), 64'd1);
    chk("ill_flag", 64'(exe_illegal), 64'd1);
    chk("ill_alu1", exe_alu1, 64'd0);
    de_ir = enc_i(12'd0, 5'd5, 5'd6, 7'b0010011);
    #1;
    chk("ill_no_pending", 64'(de_ready), 64'd1);
    tick();
    chk("ill_next_legal", 64'(exe_illegal), 64'd0);
    de_ir = enc_i(12'd1, 5'd0, 5'd0, 7'b0010011);
    #1;
    chk("x0_first_ready", 64'(de_ready), 64'd1);
    tick();
    chk("x0_first_alu2", exe_alu2, 64'd1);
    de_ir = enc_i(12'd2, 5'd0, 5'd0, 7'b0010011);
    #1;
    chk("x0_second_ready", 64'(de_ready), 64'd1);
    tick();
    chk("x0_second_alu2", exe_alu2, 64'd2);
    de_v = 1'b0; wb_v = 1'b1; wb_rd = 5'd6;
    tick();
    wb_v = 1'b0;

    // Reset mid-bundle
    de_ir = enc_i(12'd8, 5'd2, 5'd5, 7'b0000011); de_npc = '0; de_v = 1'b1; exe_ready = 1'b0;
    tick();
    de_v = 1'b0; de_ir = enc_r(5'd1, 5'd5, 5'd6);
    #1;
    chk("mid_exe_v", 64'(exe_v), 64'd1);
    chk("mid_stall", 64'(de_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_exe_v", 64'(exe_v), 64'd0);
    chk("mid_rst_alu2", exe_alu2, 64'd0);
    chk("mid_rst_de_ready", 64'(de_ready), 64'd1);
    #1;
    rst_n = 1'b1;
    regs[5] = 64'h10; de_v = 1'b1;
    tick();
    chk("post_rst_issue", 64'(exe_v), 64'd1);
    chk("post_rst_alu1", exe_alu1, 64'h10);
    de_v = 1'b0;
    tick();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
